// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus: instruction fetch, load data and store ports.
// The memory takes the slave modport and the CPU takes the master modport.
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              read_mem_ir;
    logic [ADDR_W-1:0] mem_radrs_ir;
    logic [DATA_W-1:0] instr_rdata;
    logic              read_mem_str;
    logic [ADDR_W-1:0] mem_radrs_ld;
    logic [DATA_W-1:0] ld_rdata;
    logic              write_mem;
    logic [ADDR_W-1:0] mem_wadrs;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output read_mem_ir, mem_radrs_ir,
        output read_mem_str, mem_radrs_ld,
        output write_mem, mem_wadrs, mem_wdata,
        input  instr_rdata, ld_rdata
    );

    modport slave (
        input  read_mem_ir, mem_radrs_ir,
        input  read_mem_str, mem_radrs_ld,
        input  write_mem, mem_wadrs, mem_wdata,
        output instr_rdata, ld_rdata
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word memory for the CPU's fetch/load/store ports, plus a byte-serial
// program loader that holds the CPU while it fills the array.
module cpu_mem_responder #(
    parameter int          ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048,
    parameter int          DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    cpu_mem_responder_if.slave bus,
    input  logic              prog_load_en,
    input  logic              prog_byte_valid,
    input  logic [7:0]        prog_byte,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_words,
    output logic              load_ovf,
    output logic              err_oob
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_idx;
    logic [23:0]       part;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ok_ir, ok_ld, ok_w;
    logic              cpu_we, ld_we, we;
    logic [IW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [IW-1:0] ix(input logic [ADDR_W-1:0] a);
        return a[IW-1:0];
    endfunction

    assign ok_ir = in_rng(bus.mem_radrs_ir);
    assign ok_ld = in_rng(bus.mem_radrs_ld);
    assign ok_w  = in_rng(bus.mem_wadrs);
    assign cpu_hold = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cpu_we    = 1'b0;
        ld_we     = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_we = bus.write_mem && ok_w;
                if (prog_load_en)
                    state_nxt = LOAD;
            end
            LOAD: begin
                ld_we = prog_load_en && prog_byte_valid && (byte_idx == 2'd3);
                if (!prog_load_en)
                    state_nxt = IDLE;
                else if (ld_we && load_words == LAST)
                    state_nxt = FULL;
            end
            FULL: begin
                if (!prog_load_en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        we    = cpu_we || ld_we;
        waddr = ld_we ? load_words[IW-1:0] : ix(bus.mem_wadrs);
        wdata = ld_we ? {prog_byte, part} : bus.mem_wdata;
    end

    // Array has no reset so it maps onto block RAM and survives resetn.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= IDLE;
            byte_idx         <= 2'd0;
            part             <= 24'd0;
            load_words       <= '0;
            load_ovf         <= 1'b0;
            err_oob          <= 1'b0;
            bus.instr_rdata  <= '0;
            bus.ld_rdata     <= '0;
        end else begin
            state   <= state_nxt;
            err_oob <= 1'b0;
            if (state != IDLE) begin
                bus.instr_rdata <= '0;
                bus.ld_rdata    <= '0;
            end else begin
                err_oob <= (bus.read_mem_ir && !ok_ir) ||
                           (bus.read_mem_str && !ok_ld) ||
                           (bus.write_mem && !ok_w);
                // Write-first: a same-cycle store to the read address wins.
                if (bus.read_mem_ir)
                    bus.instr_rdata <= !ok_ir ? '0 :
                        (cpu_we && bus.mem_wadrs == bus.mem_radrs_ir) ?
                        bus.mem_wdata : mem[ix(bus.mem_radrs_ir)];
                if (bus.read_mem_str)
                    bus.ld_rdata <= !ok_ld ? '0 :
                        (cpu_we && bus.mem_wadrs == bus.mem_radrs_ld) ?
                        bus.mem_wdata : mem[ix(bus.mem_radrs_ld)];
            end
            unique case (state)
                IDLE: if (prog_load_en) begin
                    byte_idx   <= 2'd0;
                    part       <= 24'd0;
                    load_words <= '0;
                    load_ovf   <= 1'b0;
                end
                LOAD: if (!prog_load_en) begin
                    byte_idx <= 2'd0;
                end else if (prog_byte_valid) begin
                    byte_idx <= byte_idx + 2'd1;
                    part     <= {prog_byte, part[23:8]};
                    if (byte_idx == 2'd3)
                        load_words <= load_words + 1'b1;
                end
                FULL: if (prog_load_en && prog_byte_valid)
                    load_ovf <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: three copies (DEPTH 2048, 4, 1024) share one stimulus
// stream so range-dependent behaviour can be compared side by side.
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic        read_mem_ir, read_mem_str, write_mem;
    logic [10:0] radrs_ir, radrs_ld, wadrs;
    logic [31:0] wdata;
    logic        prog_load_en, prog_byte_valid;
    logic [7:0]  prog_byte;

    logic        hold [3];
    logic        ovf  [3];
    logic        err  [3];
    logic [11:0] lw   [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_mem_responder_if #(.ADDR_W(11)) b0 ();
    cpu_mem_responder_if #(.ADDR_W(11)) b1 ();
    cpu_mem_responder_if #(.ADDR_W(11)) b2 ();

    assign b0.read_mem_ir  = read_mem_ir;
    assign b0.mem_radrs_ir = radrs_ir;
    assign b0.read_mem_str = read_mem_str;
    assign b0.mem_radrs_ld = radrs_ld;
    assign b0.write_mem    = write_mem;
    assign b0.mem_wadrs    = wadrs;
    assign b0.mem_wdata    = wdata;
    assign b1.read_mem_ir  = read_mem_ir;
    assign b1.mem_radrs_ir = radrs_ir;
    assign b1.read_mem_str = read_mem_str;
    assign b1.mem_radrs_ld = radrs_ld;
    assign b1.write_mem    = write_mem;
    assign b1.mem_wadrs    = wadrs;
    assign b1.mem_wdata    = wdata;
    assign b2.read_mem_ir  = read_mem_ir;
    assign b2.mem_radrs_ir = radrs_ir;
    assign b2.read_mem_str = read_mem_str;
    assign b2.mem_radrs_ld = radrs_ld;
    assign b2.write_mem    = write_mem;
    assign b2.mem_wadrs    = wadrs;
    assign b2.mem_wdata    = wdata;

    cpu_mem_responder #(.ADDR_W(11), .DEPTH(2048)) u0 (
        .clk(clk), .resetn(resetn), .bus(b0),
        .prog_load_en(prog_load_en), .prog_byte_valid(prog_byte_valid),
        .prog_byte(prog_byte), .cpu_hold(hold[0]), .load_words(lw[0]),
        .load_ovf(ovf[0]), .err_oob(err[0])
    );
    cpu_mem_responder #(.ADDR_W(11), .DEPTH(4)) u1 (
        .clk(clk), .resetn(resetn), .bus(b1),
        .prog_load_en(prog_load_en), .prog_byte_valid(prog_byte_valid),
        .prog_byte(prog_byte), .cpu_hold(hold[1]), .load_words(lw[1]),
        .load_ovf(ovf[1]), .err_oob(err[1])
    );
    cpu_mem_responder #(.ADDR_W(11), .DEPTH(1024)) u2 (
        .clk(clk), .resetn(resetn), .bus(b2),
        .prog_load_en(prog_load_en), .prog_byte_valid(prog_byte_valid),
        .prog_byte(prog_byte), .cpu_hold(hold[2]), .load_words(lw[2]),
        .load_ovf(ovf[2]), .err_oob(err[2])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        read_mem_ir  = 1'b0;
        read_mem_str = 1'b0;
        write_mem    = 1'b0;
    endtask

    logic [7:0] ld_bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        resetn = 1'b0;
        idle_bus();
        radrs_ir = '0; radrs_ld = '0; wadrs = '0; wdata = '0;
        prog_load_en = 1'b0; prog_byte_valid = 1'b0; prog_byte = '0;
        tick(); tick();
        chk("rst_ir", b0.instr_rdata, 32'h0);
        chk("rst_ld", b0.ld_rdata, 32'h0);
        chk("rst_hold", hold[0], 1'b0);
        chk("rst_lw", lw[0], 12'd0);
        chk("rst_err", err[0], 1'b0);
        resetn = 1'b1;

        // plain write then read
        write_mem = 1'b1; wadrs = 11'h005; wdata = 32'hDEADBEEF;
        tick();
        write_mem = 1'b0;
        read_mem_str = 1'b1; radrs_ld = 11'h005;
        tick();
        chk("wr_rd", b0.ld_rdata, 32'hDEADBEEF);
        chk("wr_rd_oob4", b1.ld_rdata, 32'h0);

        // same-cycle write and both reads, then hold
        write_mem = 1'b1; wadrs = 11'h00A; wdata = 32'h12345678;
        read_mem_ir = 1'b1; radrs_ir = 11'h00A; radrs_ld = 11'h00A;
        tick();
        chk("wf_ir", b0.instr_rdata, 32'h12345678);
        chk("wf_ld", b0.ld_rdata, 32'h12345678);
        idle_bus();
        radrs_ir = 11'h005; radrs_ld = 11'h005;
        tick(); tick(); tick();
        chk("hold_ir", b0.instr_rdata, 32'h12345678);
        chk("hold_ld", b0.ld_rdata, 32'h12345678);

        // loader session with reads kept enabled
        read_mem_ir = 1'b1; radrs_ir = 11'h000;
        read_mem_str = 1'b1; radrs_ld = 11'h001;
        prog_load_en = 1'b1;
        tick();
        chk("ld_hold_on", hold[0], 1'b1);
        for (int i = 0; i < 8; i++) begin
            prog_byte_valid = 1'b1; prog_byte = ld_bytes[i];
            tick();
        end
        prog_byte_valid = 1'b0;
        chk("ld_ir_noop", b0.instr_rdata, 32'h0);
        chk("ld_ld_noop", b0.ld_rdata, 32'h0);
        chk("ld_words", lw[0], 12'd2);
        prog_load_en = 1'b0;
        tick();
        chk("ld_hold_off", hold[0], 1'b0);
        tick();
        chk("ld_mem0", b0.instr_rdata, 32'h12345678);
        chk("ld_mem1", b0.ld_rdata, 32'hDEADBEEF);
        chk("ld_words_keep", lw[0], 12'd2);
        idle_bus();

        // partial word then reset
        prog_load_en = 1'b1;
        tick();
        prog_byte_valid = 1'b1; prog_byte = 8'hAA;
        tick();
        prog_byte = 8'hBB;
        tick();
        prog_byte_valid = 1'b0; prog_load_en = 1'b0; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("prst_hold", hold[0], 1'b0);
        chk("prst_lw", lw[0], 12'd0);
        read_mem_ir = 1'b1; radrs_ir = 11'h000;
        tick();
        chk("prst_mem0", b0.instr_rdata, 32'h12345678);
        idle_bus();

        // 17 bytes: overflows only the 4-word copy
        prog_load_en = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            prog_byte_valid = 1'b1; prog_byte = 8'(i + 1);
            tick();
        end
        prog_byte_valid = 1'b0;
        chk("ovf_lw4", lw[1], 12'd4);
        chk("ovf_flag4", ovf[1], 1'b1);
        chk("ovf_state4", u1.state, 2'd2);
        chk("ovf_lw2048", lw[0], 12'd4);
        chk("ovf_flag2048", ovf[0], 1'b0);
        prog_load_en = 1'b0;
        tick();
        read_mem_ir = 1'b1; radrs_ir = 11'h000;
        read_mem_str = 1'b1; radrs_ld = 11'h003;
        tick();
        chk("ovf_mem0", b1.instr_rdata, 32'h04030201);
        chk("ovf_mem3", b1.ld_rdata, 32'h100F0E0D);
        chk("ovf_sticky", ovf[1], 1'b1);
        chk("ovf_err_in", err[1], 1'b0);
        idle_bus();

        // out of range on the 1024-word copy
        write_mem = 1'b1; wadrs = 11'h3FF; wdata = 32'hCAFEF00D;
        tick();
        wadrs = 11'h7FF; wdata = 32'h0BADBAD0;
        tick();
        chk("oob_wr_err", err[2], 1'b1);
        chk("oob_wr_err2048", err[0], 1'b0);
        write_mem = 1'b0;
        read_mem_ir = 1'b1; radrs_ir = 11'h400;
        read_mem_str = 1'b1; radrs_ld = 11'h3FF;
        tick();
        chk("oob_rd_ir", b2.instr_rdata, 32'h0);
        chk("oob_rd_err", err[2], 1'b1);
        chk("oob_keep", b2.ld_rdata, 32'hCAFEF00D);
        idle_bus();
        tick();
        chk("oob_pulse", err[2], 1'b0);
        read_mem_ir = 1'b1; radrs_ir = 11'h7FF;
        tick();
        chk("oob_7ff_2048", b0.instr_rdata, 32'h0BADBAD0);
        chk("oob_7ff_1024", b2.instr_rdata, 32'h0);
        idle_bus();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Word-addressed memory slave serving the pipelined CPU's three memory ports:
  - instruction fetch read;
  - load/store-data read;
  - store write.
- Also contains a byte-serial program loader. It fills the array from an external source while the CPU is held.
- Sits between the CPU top level and the board-level program/debug interface.

Parameters:
- ADDR_W, 11, address width. Matches the CPU address buses.
- DEPTH, 2048, number of implemented 32-bit words. Must be ≤ 2^ADDR_W.
- DATA_W, 32, word width. Fixed at 32, because the loader assembles 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- read_mem_ir  in  1  instruction read enable.
- mem_radrs_ir  in  ADDR_W  instruction read address.
- instr_rdata  out  32  instruction read data, registered.
- read_mem_str  in  1  data read enable, used for LOAD.
- mem_radrs_ld  in  ADDR_W  data read address.
- ld_rdata  out  32  data read data, registered.
- write_mem  in  1  CPU write enable.
- mem_wadrs  in  ADDR_W  CPU write address.
- mem_wdata  in  32  CPU write data.
- prog_load_en  in  1  loader session request. Level signal.
- prog_byte_valid  in  1  qualifies prog_byte for one cycle.
- prog_byte  in  8  program byte. Little-endian within a word.
- cpu_hold  out  1  high while a loader session is active. Drives the CPU reset/hold.
- load_words  out  ADDR_W+1  count of complete words written in the current or last session.
- load_ovf  out  1  sticky: a byte arrived after the array was full.
- err_oob  out  1  one-cycle pulse: a CPU access had address ≥ DEPTH.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - instr_rdata, ld_rdata, load_words, err_oob and load_ovf go to 0; cpu_hold goes to 0.
  - FSM goes to IDLE; byte index and partial word are cleared.
  - Array contents are not altered by reset.
  - Reset mid-session: the partial word is discarded, and words already written remain.
- Read ports (FSM in IDLE):
  - If the enable is sampled high at edge N, rdata = mem[addr] after edge N, i.e. 1-cycle latency.
  - If the enable is low, rdata holds its previous value.
  - The two read ports are independent, and both may target the same address.
- Write port (FSM in IDLE): if write_mem is high at edge N, mem[mem_wadrs] = mem_wdata at edge N.
- Read-during-write to the same address in the same cycle returns the NEW data (write-first), on both read ports.
- Out of range (addr ≥ DEPTH, only possible when DEPTH < 2^ADDR_W):
  - An enabled read returns 0.
  - A write is dropped.
  - err_oob = 1 for exactly the following cycle, once per offending cycle even if several ports are out of range.
- FSM states: IDLE, LOAD, FULL. cpu_hold = (state != IDLE), registered.
  - IDLE → LOAD when prog_load_en is sampled high. On entry: load addr = 0, byte index = 0, load_words = 0, load_ovf = 0. A byte presented in the entry cycle is ignored.
  - LOAD, on prog_byte_valid: byte k (k = 0..3) goes to bits [8k+7:8k]. On k = 3, the assembled word is written at the load addr, then the load addr and load_words increment.
  - LOAD → FULL when the word at DEPTH-1 is written. FULL: further valid bytes are dropped and set load_ovf.
  - LOAD/FULL → IDLE when prog_load_en is sampled low. A partial word (k ≠ 0) is discarded. load_words and load_ovf hold until the next session.
- While in LOAD or FULL:
  - CPU writes are ignored.
  - instr_rdata and ld_rdata are forced to 0 (NOOP) on every cycle.
  - err_oob is suppressed.
- prog_byte_valid while in IDLE has no effect.

Test Plan:
- Write/read: write_mem at addr 0x005 with 0xDEADBEEF, then read_mem_str at 0x005 the next cycle → ld_rdata = 0xDEADBEEF one cycle after the read enable.
- Same-cycle read/write: write 0x12345678 to 0x00A while both read ports read 0x00A → instr_rdata = ld_rdata = 0x12345678 next cycle. Then hold both enables low for 3 cycles → both outputs unchanged.
- Loader: prog_load_en high, then bytes 0x78, 0x56, 0x34, 0x12, 0xEF, 0xBE, 0xAD, 0xDE, then prog_load_en low.
  - mem[0] = 0x12345678 and mem[1] = 0xDEADBEEF; load_words = 2.
  - cpu_hold is high from the cycle after the enable is sampled until the cycle after its release.
  - Both rdata outputs read 0 during the session.
- Partial word and reset: start a session and send 2 bytes, assert resetn=0 for 1 cycle, then read addr 0 → the old mem[0] contents, FSM in IDLE, cpu_hold = 0, load_words = 0.
- Overflow (DEPTH=4): send 17 bytes → load_words = 4, state FULL, load_ovf = 1. The 17th byte does not corrupt mem[0].
- OOB (DEPTH=1024): read_mem_ir at 0x400 → instr_rdata = 0 and err_oob pulses 1 cycle. A write to 0x7FF is dropped, and a following read of 0x3FF is unchanged.
